multi_btn_conditioner: RTL and testbench

MULTI_BTN_CONDITIONER -- requirements
Module: multi_btn_conditioner

---
 rtl/btn_pkg.sv | 22 ++
 rtl/btn_chan.sv | 96 +++++++++
 rtl/multi_btn_conditioner.sv | 46 ++++
 tb/tb_multi_btn_conditioner.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared constants and types for the multi-channel button conditioner.
// Long-press support is enabled by defining MULTI_BTN_LONG_PRESS_EN.
package btn_pkg;

    localparam int N_CH_DEF      = 5;
    localparam int DB_CYCLES_DEF = 16;
    localparam int LP_CYCLES_DEF = 1000;

    // Per-channel conditioned outputs (long-press pulse travels separately)
    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
        logic toggle;
    } chan_out_t;

    // Width of a counter that must hold values 0..n
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: synchroniser, debounce, edge pulses, toggle, and
// an optional long-press hold counter (MULTI_BTN_LONG_PRESS_EN).
module btn_chan
    import btn_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int LP_CYCLES = LP_CYCLES_DEF
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      sample_en,
    input  logic      btn,
`ifdef MULTI_BTN_LONG_PRESS_EN
    output logic      long_press,
`endif
    output chan_out_t q
);

    localparam int             DW      = cnt_width(DB_CYCLES);
    localparam logic [DW-1:0]  DB_LAST = DW'(DB_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic [DW-1:0] db_cnt;
    logic          level;
    logic          rise;
    logic          fall;
    logic          toggle;
    logic          accept;

    // Last qualified sample of a level change
    assign accept = sample_en && (sync_b != level) && (db_cnt == DB_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            db_cnt <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            toggle <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            rise   <= accept & sync_b;
            fall   <= accept & ~sync_b;
            if (sync_b == level) begin
                db_cnt <= '0;
            end else if (sample_en) begin
                if (db_cnt == DB_LAST) begin
                    level  <= sync_b;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end
            end
            if (accept & sync_b) begin
                toggle <= ~toggle;
            end
        end
    end

    assign q.level  = level;
    assign q.rise   = rise;
    assign q.fall   = fall;
    assign q.toggle = toggle;

`ifdef MULTI_BTN_LONG_PRESS_EN
    localparam int            LW      = cnt_width(LP_CYCLES);
    localparam logic [LW-1:0] LP_MAX  = LW'(LP_CYCLES);
    localparam logic [LW-1:0] LP_LAST = LW'(LP_CYCLES - 1);

    logic [LW-1:0] hold_cnt;
    logic          long_q;

    // Saturates at LP_MAX so the pulse fires once per press
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
            long_q   <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (!level) begin
                hold_cnt <= '0;
            end else if (sample_en && (hold_cnt != LP_MAX)) begin
                hold_cnt <= hold_cnt + LW'(1);
                long_q   <= (hold_cnt == LP_LAST);
            end
        end
    end

    assign long_press = long_q;
`endif

endmodule

// File: rtl/multi_btn_conditioner.sv
// N_CH independent button conditioners; btn_long exists only when
// MULTI_BTN_LONG_PRESS_EN is defined.
module multi_btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_CH      = N_CH_DEF,
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int LP_CYCLES = LP_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sample_en,
    input  logic [N_CH-1:0] btn_in,
`ifdef MULTI_BTN_LONG_PRESS_EN
    output logic [N_CH-1:0] btn_long,
`endif
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_rise,
    output logic [N_CH-1:0] btn_fall,
    output logic [N_CH-1:0] btn_toggle
);

    chan_out_t chan_q [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        btn_chan #(
            .DB_CYCLES (DB_CYCLES),
            .LP_CYCLES (LP_CYCLES)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .sample_en  (sample_en),
            .btn        (btn_in[i]),
`ifdef MULTI_BTN_LONG_PRESS_EN
            .long_press (btn_long[i]),
`endif
            .q          (chan_q[i])
        );

        assign btn_level[i]  = chan_q[i].level;
        assign btn_rise[i]   = chan_q[i].rise;
        assign btn_fall[i]   = chan_q[i].fall;
        assign btn_toggle[i] = chan_q[i].toggle;
    end

endmodule

// File: tb/tb_multi_btn_conditioner.sv
// Directed scoreboard bench for multi_btn_conditioner (DB_CYCLES=4,
// LP_CYCLES=10); long-press steps run when MULTI_BTN_LONG_PRESS_EN is set.
module tb_multi_btn_conditioner;

    localparam int N  = 5;
    localparam int DB = 4;
    localparam int LP = 10;

    logic         clk;
    logic         reset;
    logic         sample_en;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_rise;
    logic [N-1:0] btn_fall;
    logic [N-1:0] btn_toggle;
`ifdef MULTI_BTN_LONG_PRESS_EN
    logic [N-1:0] btn_long;
`endif

    multi_btn_conditioner #(
        .N_CH      (N),
        .DB_CYCLES (DB),
        .LP_CYCLES (LP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sample_en  (sample_en),
        .btn_in     (btn_in),
`ifdef MULTI_BTN_LONG_PRESS_EN
        .btn_long   (btn_long),
`endif
        .btn_level  (btn_level),
        .btn_rise   (btn_rise),
        .btn_fall   (btn_fall),
        .btn_toggle (btn_toggle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        logic [N-1:0] level;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] toggle;
        logic [N-1:0] lng;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    logic [N-1:0] e_level  = '0;
    logic [N-1:0] e_rise   = '0;
    logic [N-1:0] e_fall   = '0;
    logic [N-1:0] e_toggle = '0;
    logic [N-1:0] e_long   = '0;

    task automatic chk(input string tag, input logic [N-1:0] obs,
                       input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag    = tag;
        e.level  = e_level;
        e.rise   = e_rise;
        e.fall   = e_fall;
        e.toggle = e_toggle;
        e.lng    = e_long;
        sb.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, ".level"},  btn_level,  e.level);
        chk({e.tag, ".rise"},   btn_rise,   e.rise);
        chk({e.tag, ".fall"},   btn_fall,   e.fall);
        chk({e.tag, ".toggle"}, btn_toggle, e.toggle);
`ifdef MULTI_BTN_LONG_PRESS_EN
        chk({e.tag, ".long"},   btn_long,   e.lng);
`endif
    endtask

    // One clock: record what the DUT must show, then sample after the edge
    task automatic cyc(input string tag);
        push_exp(tag);
        @(posedge clk);
        #1;
        compare_front();
        e_rise = '0;
        e_fall = '0;
        e_long = '0;
    endtask

    // Clean step on one channel: 2 sync edges + DB samples to acceptance
    task automatic press(input int ch, input logic val, input int idle);
        btn_in[ch] = val;
        repeat (DB + 1) cyc($sformatf("ch%0d_v%0d_wait", ch, val));
        e_level[ch] = val;
        if (val) begin
            e_rise[ch]   = 1'b1;
            e_toggle[ch] = ~e_toggle[ch];
        end else begin
            e_fall[ch] = 1'b1;
        end
        cyc($sformatf("ch%0d_v%0d_edge", ch, val));
        repeat (idle) cyc($sformatf("ch%0d_v%0d_idle", ch, val));
    endtask

    initial begin
        int  en_cnt;
        bit  done;

        reset     = 1'b0;
        sample_en = 1'b1;
        btn_in    = '0;
        #2;
        reset = 1'b1;
        repeat (2) cyc("reset");
        reset = 1'b0;
        repeat (2) cyc("post_reset");

        // Clean press/release on channel 0
        press(0, 1'b1, 2);
        press(0, 1'b0, 2);

        // Three-cycle glitch on channel 1 must be rejected
        btn_in[1] = 1'b1;
        repeat (3) cyc("glitch_hi");
        btn_in[1] = 1'b0;
        repeat (8) cyc("glitch_lo");

        // Sample enable 1-in-4 on channel 2
        btn_in[2] = 1'b1;
        en_cnt    = 0;
        done      = 1'b0;
        for (int k = 1; k <= 48 && !done; k++) begin
            sample_en = (k % 4 == 0);
            if (k >= 3 && sample_en) begin
                if (en_cnt == DB - 1) begin
                    e_level[2]  = 1'b1;
                    e_rise[2]   = 1'b1;
                    e_toggle[2] = ~e_toggle[2];
                    done        = 1'b1;
                end else begin
                    en_cnt++;
                end
            end
            cyc("se_div");
        end
        sample_en = 1'b1;
        cyc("se_div_after");
        press(2, 1'b0, 2);

        // Two press/release pairs on channel 3
        press(3, 1'b1, 2);
        press(3, 1'b0, 2);
        press(3, 1'b1, 2);
        press(3, 1'b0, 2);

`ifdef MULTI_BTN_LONG_PRESS_EN
        press(4, 1'b1, LP - 1);
        e_long[4] = 1'b1;
        cyc("long1");
        repeat (20) cyc("long1_hold");
        press(4, 1'b0, 2);
        press(4, 1'b1, LP - 1);
        e_long[4] = 1'b1;
        cyc("long2");
        repeat (3) cyc("long2_hold");
        press(4, 1'b0, 2);
`endif

        // Reset in the middle of a debounce on channel 1
        btn_in[1] = 1'b1;
        repeat (4) cyc("rst_mid_pre");
        reset = 1'b1;
        #1;
        e_level  = '0;
        e_rise   = '0;
        e_fall   = '0;
        e_toggle = '0;
        e_long   = '0;
        push_exp("rst_async");
        compare_front();
        repeat (2) cyc("rst_mid_hold");
        reset = 1'b0;
        press(1, 1'b1, 2);
        press(1, 1'b0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
